// File: rtl/echo_test_driver.sv
// Sequenced traffic generator/checker for the echo loopback path.
// Define ECHO_TEST_CHECK_EN to build the data comparator and the err_count register.
module echo_test_driver #(
    parameter int               WIDTH   = 32,
    parameter int               MAX_OUT = 4,
    parameter logic [WIDTH-1:0] SEED    = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start__ENA,
    input  logic [15:0]      start_len,
    output logic             start__RDY,
    input  logic             enq__RDY,
    output logic             enq__ENA,
    output logic [WIDTH-1:0] enq_v,
    input  logic             ind__ENA,
    input  logic [WIDTH-1:0] ind_v,
    output logic             ind__RDY,
    output logic             done,
    output logic [15:0]      sent,
    output logic [15:0]      recv,
    output logic [15:0]      err_count,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer on an X__ENA/X__RDY pair happens on the rising CLK edge where
    // both are high; ENA never waits on anything but RDY and internal state.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state;
    logic [15:0] len;
    logic [16:0] outstanding;
    logic        ind_acc;
    logic        ind_owed;
    logic [15:0] sent_nxt;
    logic [15:0] recv_nxt;

    assign outstanding = {1'b0, sent - recv};
    assign enq__ENA    = (state == S_RUN) && enq__RDY && (sent < len) &&
                         (outstanding < 17'(MAX_OUT));
    assign enq_v       = SEED + WIDTH'(sent);
    assign ind__RDY    = (state == S_RUN) || (state == S_DRAIN);
    assign start__RDY  = (state == S_IDLE) || (state == S_DONE);
    assign done        = (state == S_DONE);
    assign dbg_state   = state;

    assign ind_acc  = ind__ENA && ind__RDY;
    assign ind_owed = (recv != sent);
    assign sent_nxt = sent + {15'd0, enq__ENA};
    assign recv_nxt = recv + {15'd0, ind_acc && ind_owed};

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= S_IDLE;
            len   <= '0;
            sent  <= '0;
            recv  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start__ENA) begin
                        len   <= start_len;
                        sent  <= '0;
                        recv  <= '0;
                        state <= (start_len == 16'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    sent <= sent_nxt;
                    recv <= recv_nxt;
                    // Last enq and last ind in the same cycle skip DRAIN entirely.
                    if (sent_nxt == len)
                        state <= (recv_nxt == len) ? S_DONE : S_DRAIN;
                end
                S_DRAIN: begin
                    recv <= recv_nxt;
                    if (recv_nxt == len)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ECHO_TEST_CHECK_EN
    logic mismatch;

    // An indication with nothing outstanding is itself an error.
    assign mismatch = ind_acc && (!ind_owed || (ind_v != SEED + WIDTH'(recv)));

    always_ff @(posedge CLK) begin
        if (!nRST)
            err_count <= '0;
        else if (start__RDY && start__ENA)
            err_count <= '0;
        else if (mismatch && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
    end
`else
    logic unused_ind_v;

    assign unused_ind_v = ^ind_v;
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_echo_test_driver.sv
// Directed bench for echo_test_driver: an echo model loops enqueued words back,
// and a monitor scoreboards every enq_v against the hand-computed sequence.
module tb_echo_test_driver;

    localparam int             W      = 32;
    localparam logic [W-1:0]   SEED_V = 32'hFFFF_FFFE;
`ifdef ECHO_TEST_CHECK_EN
    localparam int             CHK    = 1;
`else
    localparam int             CHK    = 0;
`endif

    logic          CLK = 1'b0;
    logic          nRST;
    logic          start__ENA;
    logic [15:0]   start_len;
    logic          start__RDY;
    logic          enq__RDY;
    logic          enq__ENA;
    logic [W-1:0]  enq_v;
    logic          ind__ENA;
    logic [W-1:0]  ind_v;
    logic          ind__RDY;
    logic          done;
    logic [15:0]   sent;
    logic [15:0]   recv;
    logic [15:0]   err_count;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] echo_q[$];
    int           due_q[$];
    logic [W-1:0] seq [0:9];

    int   cyc = 0;
    int   echo_idx;
    int   corrupt_idx;
    logic echo_on;
    logic spur_req;
    int   last_ind_cyc = 0;
    int   done_rise_cyc = 0;
    logic prev_done = 1'b0;

    echo_test_driver #(.WIDTH(W), .MAX_OUT(4), .SEED(SEED_V)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .start__ENA (start__ENA),
        .start_len  (start_len),
        .start__RDY (start__RDY),
        .enq__RDY   (enq__RDY),
        .enq__ENA   (enq__ENA),
        .enq_v      (enq_v),
        .ind__ENA   (ind__ENA),
        .ind_v      (ind_v),
        .ind__RDY   (ind__RDY),
        .done       (done),
        .sent       (sent),
        .recv       (recv),
        .err_count  (err_count),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Echo model and enq scoreboard, evaluated on the falling edge
    initial begin
        logic [W-1:0] w;
        ind__ENA = 1'b0;
        ind_v    = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (done && !prev_done) done_rise_cyc = cyc;
            prev_done = done;
            ind__ENA  = 1'b0;
            if (spur_req) begin
                ind__ENA = 1'b1;
                ind_v    = 32'h1234_5678;
                spur_req = 1'b0;
            end else if (echo_on && echo_q.size() > 0 && due_q[0] <= cyc) begin
                w = echo_q.pop_front();
                void'(due_q.pop_front());
                ind__ENA = 1'b1;
                ind_v    = (echo_idx == corrupt_idx) ? 32'h0000_0099 : w;
                echo_idx++;
                if (ind__RDY) last_ind_cyc = cyc;
            end
            if (enq__ENA) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL enq_unexpected: enq__ENA=1 with enq_v=%h, required no enqueue", enq_v);
                end else begin
                    chk("enq_v", enq_v, exp_q.pop_front());
                end
                echo_q.push_back(enq_v);
                due_q.push_back(cyc + 2);
            end
        end
    end

    // Driver tasks
    task automatic start_run(input int n);
        @(posedge CLK); #1;
        echo_idx = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
        start__ENA = 1'b1;
        start_len  = 16'(n);
        @(posedge CLK); #1;
        start__ENA = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required 1", budget);
        end
        @(posedge CLK); #1;
    endtask

    task automatic chk_idle_values(input string tag);
        chk({tag, "_enq_ena"},    32'(enq__ENA),   32'd0);
        chk({tag, "_ind_rdy"},    32'(ind__RDY),   32'd0);
        chk({tag, "_start_rdy"},  32'(start__RDY), 32'd1);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_sent"},       32'(sent),       32'd0);
        chk({tag, "_recv"},       32'(recv),       32'd0);
        chk({tag, "_err"},        32'(err_count),  32'd0);
        chk({tag, "_enq_v"},      enq_v,           32'hFFFF_FFFE);
    endtask

    initial begin
        seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002,
                32'h0000_0003, 32'h0000_0004, 32'h0000_0005, 32'h0000_0006, 32'h0000_0007};
        nRST        = 1'b0;
        start__ENA  = 1'b0;
        start_len   = '0;
        enq__RDY    = 1'b0;
        echo_on     = 1'b1;
        corrupt_idx = -1;
        echo_idx    = 0;
        spur_req    = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        nRST     = 1'b1;
        enq__RDY = 1'b1;
        #1;
        chk_idle_values("reset");

        // Zero-length run: done the cycle after start, no enqueue
        start_run(0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_sent", 32'(sent), 32'd0);
        chk("len0_enq_ena", 32'(enq__ENA), 32'd0);

        // len=8, echo after 2 cycles, wrapping data
        start_run(8);
        wait_done(100);
        chk("run8_sent", 32'(sent), 32'd8);
        chk("run8_recv", 32'(recv), 32'd8);
        chk("run8_err", 32'(err_count), 32'd0);
        chk("run8_done_latency", 32'(done_rise_cyc), 32'(last_ind_cyc + 1));
        chk("run8_exp_left", 32'(exp_q.size()), 32'd0);

        // Echo withheld: outstanding cap stops enqueue at 4
        echo_on = 1'b0;
        start_run(10);
        repeat (8) begin @(posedge CLK); #1; end
        chk("cap_sent", 32'(sent), 32'd4);
        chk("cap_recv", 32'(recv), 32'd0);
        chk("cap_enq_ena", 32'(enq__ENA), 32'd0);
        echo_on = 1'b1;
        wait_done(200);
        chk("cap_sent_final", 32'(sent), 32'd10);
        chk("cap_recv_final", 32'(recv), 32'd10);
        chk("cap_err", 32'(err_count), 32'd0);

        // Third echoed word corrupted to 0x99
        corrupt_idx = 2;
        start_run(5);
        wait_done(100);
        corrupt_idx = -1;
        chk("corrupt_sent", 32'(sent), 32'd5);
        chk("corrupt_recv", 32'(recv), 32'd5);
        chk("corrupt_err", 32'(err_count), 32'(CHK));

        // Indication with nothing outstanding
        enq__RDY = 1'b0;
        start_run(3);
        spur_req = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        chk("spur_recv", 32'(recv), 32'd0);
        chk("spur_sent", 32'(sent), 32'd0);
        chk("spur_err", 32'(err_count), 32'(CHK));
        enq__RDY = 1'b1;
        wait_done(100);
        chk("spur_recv_final", 32'(recv), 32'd3);
        chk("spur_err_final", 32'(err_count), 32'(CHK));

        // Reset mid-run with two words outstanding
        echo_on = 1'b0;
        start_run(10);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("midrst_sent_before", 32'(sent), 32'd2);
        enq__RDY = 1'b0;
        nRST     = 1'b0;
        echo_on  = 1'b1;
        @(posedge CLK); #1;
        nRST     = 1'b1;
        enq__RDY = 1'b1;
        exp_q.delete();
        #1;
        chk_idle_values("midrst");
        repeat (4) begin @(posedge CLK); #1; end
        chk("late_echo_recv", 32'(recv), 32'd0);
        chk("late_echo_err", 32'(err_count), 32'd0);
        chk("late_echo_start_rdy", 32'(start__RDY), 32'd1);
        chk("late_echo_done", 32'(done), 32'd0);

        // Clean run after reset
        start_run(3);
        wait_done(100);
        chk("post_sent", 32'(sent), 32'd3);
        chk("post_recv", 32'(recv), 32'd3);
        chk("post_err", 32'(err_count), 32'd0);
        chk("post_exp_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
